// File: rtl/product_accumulator.sv
// Frame accumulator for signed multiplier products: sums LEN products with
// saturation, then holds the result until the downstream consumer takes it.
module product_accumulator #(
    parameter int PW  = 16,
    parameter int AW  = 20,
    parameter int LEN = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_prod,
    input  logic          clr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_acc,
    output logic          out_ovf
);

    localparam int CW = $clog2(LEN);

    typedef enum logic {
        ST_ACC,
        ST_HOLD
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_acc;
    logic [CW-1:0]   r_cnt;
    logic            r_ovf;
    logic [AW-1:0]   r_out_acc;
    logic            r_out_ovf;
    logic            r_out_valid;

    logic [AW:0]     w_sum;
    logic [AW-1:0]   w_sat;
    logic            w_clamp;
    logic            w_accept;
    logic            w_last;

    // One guard bit above the accumulator exposes signed overflow of the add.
    assign w_sum    = {r_acc[AW-1], r_acc} + {{(AW + 1 - PW){in_prod[PW-1]}}, in_prod};
    assign w_clamp  = w_sum[AW] ^ w_sum[AW-1];
    assign w_sat    = w_clamp ? (w_sum[AW] ? {1'b1, {(AW - 1){1'b0}}}
                                           : {1'b0, {(AW - 1){1'b1}}})
                              : w_sum[AW-1:0];
    assign w_accept = in_valid && (r_state == ST_ACC) && !clr;
    assign w_last   = (r_cnt == CW'(LEN - 1));

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        case (r_state)
            ST_ACC: begin
                in_ready = 1'b1;
                if (w_accept && w_last) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    w_state_nxt = ST_ACC;
                end
            end
            default: w_state_nxt = ST_ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_acc   <= '0;
            r_out_ovf   <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (r_state == ST_ACC) begin
            if (clr) begin
                r_acc <= '0;
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else if (w_accept) begin
                if (w_last) begin
                    r_out_acc   <= w_sat;
                    r_out_ovf   <= r_ovf | w_clamp;
                    r_out_valid <= 1'b1;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                    r_ovf       <= 1'b0;
                end else begin
                    r_acc <= w_sat;
                    r_ovf <= r_ovf | w_clamp;
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_acc   = r_out_acc;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench: a saturating frame-sum model feeds expected results to a
// queue; an independent monitor pops and compares on each output handshake.
module tb_product_accumulator;

    localparam int PW  = 16;
    localparam int AW  = 20;
    localparam int LEN = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid0, clr0, out_ready0;
    logic [PW-1:0] in_prod0;
    logic          in_ready0, out_valid0, out_ovf0;
    logic [AW-1:0] out_acc0;

    logic          in_valid1, clr1, out_ready1;
    logic [15:0]   in_prod1;
    logic          in_ready1, out_valid1, out_ovf1;
    logic [15:0]   out_acc1;

    int n_checks = 0;
    int n_errors = 0;

    longint q_acc[$];
    bit     q_ovf[$];

    longint m_acc;
    int     m_cnt;
    bit     m_ovf;
    bit     m_pending;
    int     n_frames;

    bit     prev_hold;
    longint prev_acc;
    bit     prev_ovf;

    product_accumulator #(.PW(PW), .AW(AW), .LEN(LEN)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_prod(in_prod0), .clr(clr0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_acc(out_acc0), .out_ovf(out_ovf0)
    );

    product_accumulator #(.PW(16), .AW(16), .LEN(4)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_prod(in_prod1), .clr(clr1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_acc(out_acc1), .out_ovf(out_ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sat(input longint s, input int aw, output bit clamped);
        longint hi = (longint'(1) <<< (aw - 1)) - 1;
        longint lo = -(longint'(1) <<< (aw - 1));
        clamped = 1'b0;
        if (s > hi) begin sat = hi; clamped = 1'b1; end
        else if (s < lo) begin sat = lo; clamped = 1'b1; end
        else sat = s;
    endfunction

    task automatic model_clear();
        m_acc = 0;
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    // One clock of stimulus on dut0 followed by the model's view of that edge.
    task automatic step(input bit v, input logic [PW-1:0] p, input bit c, input bit r);
        bit cl;
        @(posedge clk);
        #1;
        in_valid0  = v;
        in_prod0   = p;
        clr0       = c;
        out_ready0 = r;
        @(negedge clk);
        chk("in_ready", longint'(in_ready0), longint'(!m_pending));
        chk("out_valid", longint'(out_valid0), longint'(m_pending));
        if (m_pending) begin
            if (r) m_pending = 1'b0;
        end else if (c) begin
            model_clear();
        end else if (v) begin
            m_acc = sat(m_acc + longint'($signed(p)), AW, cl);
            m_ovf = m_ovf | cl;
            m_cnt++;
            if (m_cnt == LEN) begin
                q_acc.push_back(m_acc);
                q_ovf.push_back(m_ovf);
                m_pending = 1'b1;
                n_frames++;
                model_clear();
            end
        end
    endtask

    task automatic step1(input bit v, input logic [15:0] p, input bit r);
        @(posedge clk);
        #1;
        in_valid1  = v;
        in_prod1   = p;
        out_ready1 = r;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid0) begin
            if (prev_hold) begin
                chk("hold_acc_stable", longint'($signed(out_acc0)), prev_acc);
                chk("hold_ovf_stable", longint'(out_ovf0), longint'(prev_ovf));
            end
            if (out_ready0) begin
                if (q_acc.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_result: got %0d expected none", $signed(out_acc0));
                end else begin
                    chk("out_acc", longint'($signed(out_acc0)), q_acc.pop_front());
                    chk("out_ovf", longint'(out_ovf0), longint'(q_ovf.pop_front()));
                end
            end
            prev_hold = !out_ready0;
            prev_acc  = longint'($signed(out_acc0));
            prev_ovf  = out_ovf0;
        end else begin
            prev_hold = 1'b0;
        end
    end

    initial begin
        logic [31:0] rnd;
        int cycles;
        rst_n = 1'b0;
        in_valid0 = 0; in_prod0 = '0; clr0 = 0; out_ready0 = 0;
        in_valid1 = 0; in_prod1 = '0; clr1 = 0; out_ready1 = 0;
        model_clear();
        m_pending = 0;
        n_frames  = 0;
        prev_hold = 0;
        #1;
        chk("rst_out_valid", longint'(out_valid0), 0);
        chk("rst_out_acc", longint'(out_acc0), 0);
        chk("rst_out_ovf", longint'(out_ovf0), 0);
        chk("rst_in_ready", longint'(in_ready0), 1);
        #11 rst_n = 1'b1;

        // Narrow accumulator: saturating frame, then a clean frame.
        for (int i = 0; i < 4; i++) step1(1, 16'd28672, 0);
        step1(0, 16'd0, 0);
        @(negedge clk);
        chk("sat_valid", longint'(out_valid1), 1);
        chk("sat_acc", longint'($signed(out_acc1)), 32767);
        chk("sat_ovf", longint'(out_ovf1), 1);
        chk("sat_in_ready", longint'(in_ready1), 0);
        step1(0, 16'd0, 1);
        step1(0, 16'd0, 0);
        @(negedge clk);
        chk("sat_released", longint'(out_valid1), 0);
        for (int i = 0; i < 4; i++) step1(1, 16'd1, 0);
        step1(0, 16'd0, 0);
        @(negedge clk);
        chk("small_valid", longint'(out_valid1), 1);
        chk("small_acc", longint'($signed(out_acc1)), 4);
        chk("small_ovf", longint'(out_ovf1), 0);
        step1(0, 16'd0, 1);

        // Back-to-back frame with immediate consumption.
        step(1, 16'd100, 0, 1);
        step(1, 16'hFFE2, 0, 1);
        step(1, 16'd16384, 0, 1);
        step(1, 16'hFFFF, 0, 1);
        step(0, 16'd0, 0, 1);
        step(0, 16'd0, 0, 1);

        // Held result with ignored in_valid during hold.
        for (int i = 0; i < 4; i++) step(1, 16'hC000, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 16'd77, 0, 0);
        step(0, 16'd0, 0, 1);

        // Abort discards the simultaneous product.
        step(1, 16'd500, 0, 0);
        step(1, 16'd500, 0, 0);
        step(1, 16'd7, 1, 0);
        for (int i = 1; i <= 4; i++) step(1, 16'(i), 0, 0);
        step(0, 16'd0, 0, 1);

        // Reset mid-frame.
        for (int i = 0; i < 3; i++) step(1, 16'd9, 0, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_out_valid", longint'(out_valid0), 0);
        chk("async_out_acc", longint'(out_acc0), 0);
        chk("async_out_ovf", longint'(out_ovf0), 0);
        chk("async_in_ready", longint'(in_ready0), 1);
        model_clear();
        m_pending = 0;
        q_acc.delete();
        q_ovf.delete();
        in_valid0 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1, 16'd5, 0, 0);
        step(0, 16'd0, 0, 1);

        // Randomised frames with gaps, backpressure and occasional aborts.
        cycles = 0;
        while (n_frames < 1005 && cycles < 40000) begin
            rnd = $urandom();
            step(($urandom_range(0, 9) < 7), rnd[15:0], ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 9) < 6));
            cycles++;
        end
        if (n_frames < 1005) chk("random_frame_budget", longint'(n_frames), 1005);
        repeat (3) step(0, 16'd0, 0, 1);
        chk("scoreboard_drained", longint'(q_acc.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL provide parameter PW, default 16, signed product width; matches the 2*width output of the upstream Booth multiplier.
REQ-002 SHALL provide parameter AW, default 20, signed accumulator/result width, AW >= PW.
REQ-003 SHALL provide parameter LEN, default 4, number of products per frame (dot-product length), LEN >= 2.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  in_prod holds a valid product.
REQ-008 in_ready  output  1  block accepts a product this cycle.
REQ-009 in_prod  input  PW  signed product from the multiplier.
REQ-010 clr  input  1  synchronous abort of the frame being accumulated.
REQ-011 out_valid  output  1  out_acc/out_ovf hold a completed frame result.
REQ-012 out_ready  input  1  downstream consumes the result.
REQ-013 out_acc  output  AW  signed saturated frame sum.
REQ-014 out_ovf  output  1  saturation occurred at least once in this frame.

Function
REQ-015 SHALL implement two states: ACC (accumulating) and HOLD (result pending).
REQ-016 in_ready SHALL be 1 in ACC and 0 in HOLD; a product is accepted only on in_valid && in_ready at a rising edge.
REQ-017 On each accept, acc SHALL become sat(acc + sign-extended in_prod); sat clamps to [-2^(AW-1), 2^(AW-1)-1], and any clamp sets the sticky frame overflow flag.
REQ-018 A frame count SHALL track accepted products 0..LEN-1; it increments on each accept in ACC.
REQ-019 When the accept brings the count to LEN (LEN-th product), on that same edge: out_acc <= final saturated sum, out_ovf <= final sticky flag, out_valid <= 1, state -> HOLD, acc/count/flag -> 0.
REQ-020 Latency: out_valid SHALL assert in the cycle after the edge that accepted the LEN-th product.
REQ-021 In HOLD, out_acc/out_ovf SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 In HOLD with out_ready=1: out_valid -> 0, state -> ACC on that edge; the next product is accepted no earlier than the following cycle (min frame period LEN+1 cycles).
REQ-023 clr=1 in ACC SHALL zero acc, count and flag on that edge and take priority over a simultaneous accept (product discarded).
REQ-024 clr=1 in HOLD SHALL not alter the pending result, out_valid, or the HOLD->ACC transition; the new frame starts clean regardless.
REQ-025 in_valid without a handshake (in_ready=0) SHALL have no effect; idle cycles inside a frame SHALL not change acc or count.
REQ-026 out_ready while out_valid=0 SHALL be ignored.

Reset
REQ-027 rst_n=0 SHALL immediately force state=ACC, acc=0, count=0, flag=0, out_valid=0, out_acc=0, out_ovf=0; in_ready=1 while in reset deasserted only by state, i.e. 1 after reset.
REQ-028 Reset asserted mid-frame or in HOLD SHALL discard all partial and pending results; first accept after release starts a new frame at count 0.

Verification
REQ-029 Defaults, products 100, -30, 16384, -1 back-to-back, out_ready=1 -> out_valid one cycle after 4th accept, out_acc=16453, out_ovf=0, out_valid drops next edge.
REQ-030 Defaults, frame of 4x(-16384) with out_ready=0 for 5 cycles -> out_acc=-65536 held stable, in_ready=0 throughout hold, new in_valid ignored until release.
REQ-031 AW=16,PW=16, products 28672 x4 -> out_acc=32767, out_ovf=1; next frame 1,1,1,1 -> out_acc=4, out_ovf=0.
REQ-032 Defaults, accept 500, 500, then clr=1 with in_valid=1, in_prod=7 -> product dropped; following 4 products 1,2,3,4 -> out_acc=10.
REQ-033 Defaults, accept 3 products then rst_n=0 for 2 cycles mid-cycle -> all outputs 0 asynchronously; after release products 5,5,5,5 -> out_acc=20.
REQ-034 Random in_valid/out_ready gaps over 1000 frames -> every out_acc matches a saturating reference model, no product lost or duplicated.
